// File: rtl/onehot_rr_arbiter_if.sv
// Grant bus between the round-robin arbiter and its requesters/encoder stage.
// The master side issues grants; the slave side requests and acknowledges.
interface onehot_rr_arbiter_if #(
  parameter int N = 8
);
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic         gnt_ack;
  logic         timeout;

  modport master (
    input  req,
    input  gnt_ack,
    output gnt,
    output gnt_valid,
    output timeout
  );

  modport slave (
    output req,
    output gnt_ack,
    input  gnt,
    input  gnt_valid,
    input  timeout
  );
endinterface

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter issuing a registered one-hot grant, held until acknowledged,
// with an optional watchdog that revokes grants that are never acknowledged.
module onehot_rr_arbiter #(
  parameter int N       = 8,
  parameter int TIMEOUT = 0,
  parameter int TW      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  onehot_rr_arbiter_if.master   bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [TW-1:0] TLIMIT = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_next;
  logic [PW-1:0] ptr, ptr_next;
  logic [N-1:0]  gnt_q, gnt_next;
  logic [TW-1:0] timer, timer_next;
  logic          timeout_q, timeout_next;
  logic [PW-1:0] ptr_after;

  // Lowest rotated offset wins, so scan offsets high-to-low and let later hits overwrite.
  function automatic logic [N-1:0] search(input logic [N-1:0] r, input logic [PW-1:0] p);
    logic [N-1:0] g;
    int           idx;
    g = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(p) + i) % N;
      if (r[idx]) begin
        g      = '0;
        g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [PW-1:0] rotate_past(input logic [N-1:0] g);
    int nxt;
    nxt = 0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) nxt = (i + 1) % N;
    end
    return PW'(nxt);
  endfunction

  assign ptr_after = rotate_past(gnt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_q     <= '0;
      timer     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      gnt_q     <= gnt_next;
      timer     <= timer_next;
      timeout_q <= timeout_next;
    end
  end

  // On ack, the search restarts just past the granted index, so that requester
  // naturally falls to lowest priority without any extra masking.
  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    gnt_next     = gnt_q;
    timer_next   = timer;
    timeout_next = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          gnt_next   = search(bus.req, ptr);
          timer_next = '0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (bus.gnt_ack) begin
          ptr_next   = ptr_after;
          gnt_next   = search(bus.req, ptr_after);
          timer_next = '0;
          state_next = (|bus.req) ? GRANT : IDLE;
        end else if (TIMEOUT > 0) begin
          if (timer == TLIMIT) begin
            ptr_next     = ptr_after;
            gnt_next     = '0;
            timer_next   = '0;
            timeout_next = 1'b1;
            state_next   = IDLE;
          end else begin
            timer_next = timer + TW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Scoreboard bench for onehot_rr_arbiter: one instance without watchdog, one with TIMEOUT=4.
module tb_onehot_rr_arbiter;

  logic clk;
  logic rst;

  typedef struct {
    logic [7:0] gnt;
    logic       valid;
    logic       tmo;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  onehot_rr_arbiter_if #(.N(8)) if0 ();
  onehot_rr_arbiter_if #(.N(8)) if4 ();

  onehot_rr_arbiter #(.N(8), .TIMEOUT(0), .TW(8)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.master)
  );

  onehot_rr_arbiter #(.N(8), .TIMEOUT(4), .TW(8)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives the untimed DUT's inputs and records what it must show after the next edge.
  task automatic applyStimulus(input logic r, input logic [7:0] rq, input logic ack,
                               input logic [7:0] egnt, input logic etmo);
    exp_t e;
    rst         = r;
    if0.req     = rq;
    if0.gnt_ack = ack;
    e.gnt       = egnt;
    e.valid     = (egnt != 8'h00);
    e.tmo       = etmo;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      applyStimulus((i < 2), 8'hFF, 1'b0, (i < 2) ? 8'h00 : 8'h01, 1'b0);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({if0.gnt, if0.gnt_valid, if0.timeout} !== {e.gnt, e.valid, e.tmo}) begin
        failures++;
        $display("[TB] FAIL reset[%0d] got gnt=%h v=%b t=%b want gnt=%h v=%b t=%b",
                 i, if0.gnt, if0.gnt_valid, if0.timeout, e.gnt, e.valid, e.tmo);
      end
    end
  endtask

  task automatic test_rotation();
    exp_t       e;
    logic [7:0] walk [8];
    walk = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'hFF, 1'b1, walk[i], 1'b0);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({if0.gnt, if0.gnt_valid, if0.timeout} !== {e.gnt, e.valid, e.tmo}) begin
        failures++;
        $display("[TB] FAIL rotation[%0d] got gnt=%h v=%b t=%b want gnt=%h v=%b t=%b",
                 i, if0.gnt, if0.gnt_valid, if0.timeout, e.gnt, e.valid, e.tmo);
      end
    end
  endtask

  // Grant index 5 first so the pointer sits at 6, then check the wrap to 0 and the skip to 3.
  task automatic test_wrap_skip();
    exp_t       e;
    logic [7:0] rq  [4];
    logic [7:0] exg [4];
    rq  = '{8'h20, 8'h09, 8'h09, 8'h00};
    exg = '{8'h20, 8'h01, 8'h08, 8'h00};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, rq[i], 1'b1, exg[i], 1'b0);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({if0.gnt, if0.gnt_valid, if0.timeout} !== {e.gnt, e.valid, e.tmo}) begin
        failures++;
        $display("[TB] FAIL wrap_skip[%0d] got gnt=%h v=%b t=%b want gnt=%h v=%b t=%b",
                 i, if0.gnt, if0.gnt_valid, if0.timeout, e.gnt, e.valid, e.tmo);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      if (i < 6)       applyStimulus(1'b0, 8'h04, 1'b0, 8'h04, 1'b0);
      else if (i < 8)  applyStimulus(1'b0, 8'h00, 1'b0, 8'h04, 1'b0);
      else             applyStimulus(1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({if0.gnt, if0.gnt_valid, if0.timeout} !== {e.gnt, e.valid, e.tmo}) begin
        failures++;
        $display("[TB] FAIL hold[%0d] got gnt=%h v=%b t=%b want gnt=%h v=%b t=%b",
                 i, if0.gnt, if0.gnt_valid, if0.timeout, e.gnt, e.valid, e.tmo);
      end
    end
  endtask

  // Pointer is 3 here, so without the reset 8'h41 would grant 8'h40 instead of 8'h01.
  task automatic test_reset_mid_grant();
    exp_t       e;
    logic       rs  [4];
    logic [7:0] rq  [4];
    logic       ak  [4];
    logic [7:0] exg [4];
    rs  = '{1'b0, 1'b1, 1'b0, 1'b0};
    rq  = '{8'h40, 8'h40, 8'h41, 8'h00};
    ak  = '{1'b0, 1'b0, 1'b0, 1'b1};
    exg = '{8'h40, 8'h00, 8'h01, 8'h00};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(rs[i], rq[i], ak[i], exg[i], 1'b0);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({if0.gnt, if0.gnt_valid, if0.timeout} !== {e.gnt, e.valid, e.tmo}) begin
        failures++;
        $display("[TB] FAIL reset_mid[%0d] got gnt=%h v=%b t=%b want gnt=%h v=%b t=%b",
                 i, if0.gnt, if0.gnt_valid, if0.timeout, e.gnt, e.valid, e.tmo);
      end
    end
  endtask

  // Four live cycles, one revoked cycle with the pulse, re-grant, then an ack on cycle four.
  task automatic test_watchdog();
    exp_t       e;
    logic [7:0] rq  [11];
    logic       ak  [11];
    logic [7:0] exg [11];
    logic       ext [11];
    rq  = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00};
    ak  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exg = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00};
    ext = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if4.req     = rq[i];
      if4.gnt_ack = ak[i];
      e.gnt       = exg[i];
      e.valid     = (exg[i] != 8'h00);
      e.tmo       = ext[i];
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({if4.gnt, if4.gnt_valid, if4.timeout} !== {e.gnt, e.valid, e.tmo}) begin
        failures++;
        $display("[TB] FAIL watchdog[%0d] got gnt=%h v=%b t=%b want gnt=%h v=%b t=%b",
                 i, if4.gnt, if4.gnt_valid, if4.timeout, e.gnt, e.valid, e.tmo);
      end
    end
    if4.gnt_ack = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    if0.req     = 8'h00;
    if0.gnt_ack = 1'b0;
    if4.req     = 8'h00;
    if4.gnt_ack = 1'b0;
    test_reset();
    test_rotation();
    test_wrap_skip();
    test_hold();
    test_reset_mid_grant();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onehot_rr_arbiter.md
Name: onehot_rr_arbiter

Overview:
- Round-robin arbiter that produces the 8-bit one-hot select consumed by the octal_binary encoder stage, which turns it into a 3-bit index.
- It samples up to N request lines and issues exactly one registered, one-hot grant at a time.
- It holds each grant until the downstream stage acknowledges it, then rotates priority so every requester is served fairly.
- An optional watchdog reclaims a grant that is never acknowledged.

Parameters:
N, 8, number of request lines and width of the one-hot grant (the encoder stage requires 8).
TIMEOUT, 0, number of cycles a grant may wait for gnt_ack before it is revoked; 0 disables the watchdog.
TW, 8, width of the internal timeout counter; must satisfy TIMEOUT < 2**TW.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
req  input  N  request vector; any number of bits may be set.
gnt  output  N  registered one-hot grant; all-zero when idle. Feeds the encoder input directly.
gnt_valid  output  1  high while gnt holds a live grant; equals |gnt.
gnt_ack  input  1  downstream accepts the current grant; meaningful only while gnt_valid=1.
timeout  output  1  one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset (rst=1 at a rising edge): gnt=0, gnt_valid=0, timeout=0, ptr=0 (index 0 has highest priority), timer=0, state=IDLE. Reset overrides every other event, including a reset asserted mid-grant.
- Invariant: gnt is either all-zero or exactly one-hot in every cycle. gnt_valid == |gnt.
- Priority search: from req, pick the first set bit scanning indices ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap-around modulo N).
- State IDLE:
  - If req != 0, the next edge loads gnt with the search result, sets gnt_valid=1, clears timer and moves to GRANT.
  - Latency from req sampled high to gnt visible is 1 cycle.
  - If req == 0, stay in IDLE with outputs zero.
- State GRANT, gnt is frozen:
  - Changes on req, including the granted requester dropping its bit, do not alter gnt.
  - gnt_ack=1: ptr <= (granted index + 1) mod N.
    - In the same edge, re-run the search over the current req using the new ptr, with the just-granted bit taking lowest priority.
    - If a bit is found, load the new gnt and stay in GRANT (back-to-back grant, no idle bubble).
    - Otherwise clear gnt and go to IDLE.
  - gnt_ack=0 and TIMEOUT>0: increment timer. When timer reaches TIMEOUT-1 (grant has been live TIMEOUT cycles):
    - revoke the grant (gnt=0);
    - pulse timeout=1 for one cycle;
    - ptr <= (granted index + 1) mod N;
    - go to IDLE; re-arbitration happens on the following cycle.
  - gnt_ack=1 in the same cycle the watchdog expires: the ack wins, timeout stays 0.
  - TIMEOUT=0: the grant is held indefinitely until gnt_ack.
- gnt_ack while in IDLE is ignored.
- ptr changes only on ack or timeout, never on new requests.
- All outputs are registered; there is no combinational path from req or gnt_ack to any output.

Test Plan:
- Reset: rst=1 for 2 cycles with req=8'hFF -> gnt=8'h00, gnt_valid=0, timeout=0. Release rst -> gnt=8'b00000001 one cycle later.
- Rotation: req=8'hFF held, gnt_ack=1 every cycle -> gnt walks 01,02,04,08,10,20,40,80,01, one step per cycle, with no idle cycles.
- Wrap and skip: ptr=6 (after granting index 5), req=8'b00001001 -> gnt=8'b00000001. After ack, with req unchanged -> gnt=8'b00001000.
- Hold: req=8'b00000100, no ack for 5 cycles, then drop req -> gnt stays 8'b00000100 until gnt_ack=1, then goes to 8'h00 and gnt_valid=0.
- Watchdog: TIMEOUT=4, req=8'b00010000, ack never asserted -> gnt=8'b00010000 for exactly 4 cycles, then gnt=0 with timeout=1 for one cycle, then re-grant 8'b00010000. Ack asserted on the 4th cycle -> no timeout pulse.
- Reset mid-grant: gnt=8'b01000000 live, assert rst for 1 cycle -> gnt=0 next edge and ptr=0. With req=8'b01000001 after release -> gnt=8'b00000001.
